// File: rtl/tnew_scoreboard.sv
// tnew_scoreboard: Tuse/Tnew hazard scoreboard for the MIPS D stage.
// It tracks in-flight destination registers over STAGES downstream stages,
// ages their Tnew each cycle, and produces the D-stage stall, the per-operand
// forwarding selects and the HI/LO busy interlock for mult/div.
module tnew_scoreboard #(
  parameter int STAGES   = 3,
  parameter int AW       = 5,
  parameter int TW       = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int SW       = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_is_div,
  input  logic          d_md_use,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  // All-ones Tuse means the operand is not read at all.
  localparam logic [TW-1:0] TUSE_NONE = '1;
  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  // Saturating decrement used for Tnew ageing: a result that already exists
  // stays at zero for the rest of its trip down the pipe.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Entry 1 is the youngest (stage E); entry STAGES is the oldest.
  logic [STAGES:1] vld_q, vld_d;
  logic [AW-1:0]   dst_q  [1:STAGES];
  logic [AW-1:0]   dst_d  [1:STAGES];
  logic [TW-1:0]   tnew_q [1:STAGES];
  logic [TW-1:0]   tnew_d [1:STAGES];
  logic [CW-1:0]   md_cnt_q, md_cnt_d;

  logic            rs_hit, rs_hz, rt_hit, rt_hz;
  logic [SW-1:0]   rs_sel, rt_sel;
  logic            md_busy_int;
  logic            issue;
  logic            md_issue;

  // Youngest-match search for each source operand against the tracked entries.
  always_comb begin
    rs_hit = 1'b0;
    rs_hz  = 1'b0;
    rs_sel = '0;
    rt_hit = 1'b0;
    rt_hz  = 1'b0;
    rt_sel = '0;
    if (d_tuse_rs != TUSE_NONE && d_rs != '0) begin
      for (int k = 1; k <= STAGES; k++) begin
        if (!rs_hit && vld_q[k] && dst_q[k] == d_rs) begin
          rs_hit = 1'b1;
          if (tnew_q[k] > d_tuse_rs) rs_hz = 1'b1;
          else if (tnew_q[k] == '0) rs_sel = SW'(k);
        end
      end
    end
    if (d_tuse_rt != TUSE_NONE && d_rt != '0) begin
      for (int k = 1; k <= STAGES; k++) begin
        if (!rt_hit && vld_q[k] && dst_q[k] == d_rt) begin
          rt_hit = 1'b1;
          if (tnew_q[k] > d_tuse_rt) rt_hz = 1'b1;
          else if (tnew_q[k] == '0) rt_sel = SW'(k);
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held so that the undefined
  // pre-reset state never leaks out; flush deliberately does not appear here.
  always_comb begin
    md_busy_int = (md_cnt_q != '0);
    md_busy     = !reset && md_busy_int;
    stall       = !reset && d_valid &&
                  (rs_hz || rt_hz || ((d_md_use || d_md_start) && md_busy_int));
    fwd_rs_sel  = reset ? '0 : rs_sel;
    fwd_rt_sel  = reset ? '0 : rt_sel;
  end

  // Next-state: shift entries down with Tnew ageing, capture D into entry 1,
  // and run the HI/LO busy counter.
  always_comb begin
    issue    = d_valid && !stall && !flush;
    md_issue = issue && d_md_start;

    // Stage 1: capture from D (only real register writes) or insert a bubble
    vld_d[1]  = issue && d_dst != '0 && d_tnew != '0;
    dst_d[1]  = d_dst;
    tnew_d[1] = sat_dec(d_tnew);

    // Stages 2..STAGES: age the previous entry by one cycle
    for (int k = 2; k <= STAGES; k++) begin
      vld_d[k]  = vld_q[k-1] && !flush;
      dst_d[k]  = dst_q[k-1];
      tnew_d[k] = sat_dec(tnew_q[k-1]);
    end

    md_cnt_d = md_cnt_q;
    if (md_issue) md_cnt_d = d_md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    else if (md_cnt_q != '0) md_cnt_d = md_cnt_q - CW'(1);
  end

  // Control state: entry valids and the md counter are the only reset flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      md_cnt_q <= '0;
    end else begin
      vld_q    <= vld_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Entry payload: qualified by the valids, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 1; k <= STAGES; k++) begin
      dst_q[k]  <= dst_d[k];
      tnew_q[k] <= tnew_d[k];
    end
  end

endmodule

// File: tb/tb_tnew_scoreboard.sv
// Directed testbench for tnew_scoreboard with hand-computed expectations.
module tb_tnew_scoreboard;

  localparam int STAGES = 3;
  localparam int AW = 5;
  localparam int TW = 3;
  localparam int SW = $clog2(STAGES + 1);
  localparam logic [TW-1:0] NONE = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic          d_valid;
  logic [AW-1:0] d_rs, d_rt, d_dst;
  logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic          d_md_start, d_md_is_div, d_md_use, flush;
  logic          stall, md_busy;
  logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;

  int n_tests = 0;
  int n_fail  = 0;

  tnew_scoreboard #(.STAGES(STAGES), .AW(AW), .TW(TW), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_is_div(d_md_is_div), .d_md_use(d_md_use),
    .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 1'b0; d_rs = '0; d_rt = '0; d_tuse_rs = NONE; d_tuse_rt = NONE;
    d_dst = '0; d_tnew = '0; d_md_start = 1'b0; d_md_is_div = 1'b0; d_md_use = 1'b0;
  endtask

  task automatic set_d(input int rs, input int trs, input int rt, input int trt,
                       input int dst, input int tnew);
    idle();
    d_valid = 1'b1;
    d_rs = AW'(rs); d_tuse_rs = TW'(trs);
    d_rt = AW'(rt); d_tuse_rt = TW'(trt);
    d_dst = AW'(dst); d_tnew = TW'(tnew);
  endtask

  task automatic drain();
    idle();
    repeat (STAGES + 1) tick();
  endtask

  initial begin
    flush = 1'b0;
    reset = 1'b1;
    set_d(8, 0, 0, NONE, 0, 0);
    #2;
    chk("rst_stall_pre", stall, 0);
    chk("rst_busy_pre", md_busy, 0);
    chk("rst_sel_pre", fwd_rs_sel, 0);
    tick(); tick();
    chk("rst_stall", stall, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_sel", fwd_rs_sel, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_stall", stall, 0);
    drain();

    // Load followed by a branch reading the loaded register
    set_d(0, NONE, 0, NONE, 8, 3);
    #1 chk("ld_issue_stall", stall, 0);
    tick();
    set_d(8, 0, 0, NONE, 0, 0);
    #1 chk("ld_br_stall1", stall, 1);
    tick();
    chk("ld_br_stall2", stall, 1);
    tick();
    chk("ld_br_go", stall, 0);
    chk("ld_br_sel", fwd_rs_sel, 3);
    drain();

    // ALU to ALU with tuse=1: no stall, forwarded later
    set_d(0, NONE, 0, NONE, 9, 2);
    tick();
    set_d(0, NONE, 9, 1, 0, 0);
    #1 chk("alu_t1_stall", stall, 0);
    chk("alu_t1_sel", fwd_rt_sel, 0);
    drain();

    // ALU to ALU with tuse=0: one bubble then forward from stage 2
    set_d(0, NONE, 0, NONE, 9, 2);
    tick();
    set_d(0, NONE, 9, 0, 0, 0);
    #1 chk("alu_t0_stall", stall, 1);
    tick();
    chk("alu_t0_go", stall, 0);
    chk("alu_t0_sel", fwd_rt_sel, 2);
    drain();

    // Two writes of reg 10: the younger one decides
    set_d(0, NONE, 0, NONE, 10, 2);
    tick();
    set_d(0, NONE, 0, NONE, 10, 2);
    tick();
    set_d(0, NONE, 10, 0, 0, 0);
    #1 chk("yw_stall", stall, 1);
    tick();
    chk("yw_go", stall, 0);
    chk("yw_sel", fwd_rt_sel, 2);
    drain();

    // Writes to $0 are never tracked
    set_d(0, NONE, 0, NONE, 0, 3);
    tick();
    set_d(0, 0, 0, NONE, 0, 0);
    #1 chk("r0_stall", stall, 0);
    chk("r0_sel", fwd_rs_sel, 0);
    drain();

    // mult then mfhi: busy for exactly MULT_LAT cycles
    idle();
    d_valid = 1'b1; d_md_start = 1'b1; d_md_use = 1'b1;
    #1 chk("mult_issue_stall", stall, 0);
    chk("mult_issue_busy", md_busy, 0);
    tick();
    idle();
    d_valid = 1'b1; d_md_use = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mfhi_stall_%0d", i), stall, 1);
      chk($sformatf("mfhi_busy_%0d", i), md_busy, 1);
      tick();
    end
    chk("mfhi_go", stall, 0);
    chk("mfhi_idle", md_busy, 0);
    drain();

    // div, then reset three cycles later kills the busy count
    idle();
    d_valid = 1'b1; d_md_start = 1'b1; d_md_is_div = 1'b1; d_md_use = 1'b1;
    tick();
    idle();
    tick(); tick();
    chk("div_busy", md_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("div_rst_busy", md_busy, 0);
    drain();

    // Flush discards the tracked load
    set_d(0, NONE, 0, NONE, 8, 3);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_d(8, 0, 0, NONE, 0, 0);
    #1 chk("flush_stall", stall, 0);
    chk("flush_sel", fwd_rs_sel, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tnew_scoreboard.md
# tnew_scoreboard

Parametrised hazard scoreboard for the pipelined MIPS core, sitting beside the D stage. It consumes the per-instruction Tuse/Tnew codes produced by the decode-side T-coder and tracks every in-flight destination register through STAGES downstream stages, ageing its Tnew each cycle. It produces the D-stage stall, per-operand forwarding selects, and a multiply/divide busy interlock with configurable latencies.

## Interface
- STAGES, 3: number of tracked stages after D (1 = E, 2 = M, 3 = W, …)
- AW, 5: register address width
- TW, 3: Tuse/Tnew width; all-ones encodes TUSE_NONE (operand not read)
- MULT_LAT, 5: HI/LO busy cycles after a multiply issues
- DIV_LAT, 10: HI/LO busy cycles after a divide issues
- SW = $clog2(STAGES+1): derived width of the forwarding selects
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- d_valid  in  1  D stage holds a real instruction
- d_rs, d_rt  in  AW  source register addresses
- d_tuse_rs, d_tuse_rt  in  TW  cycles from D until the operand is needed; TUSE_NONE = unused
- d_dst  in  AW  destination register
- d_tnew  in  TW  cycles from D until the result exists; 0 = no register write
- d_md_start  in  1  instruction starts a mult/div
- d_md_is_div  in  1  selects DIV_LAT instead of MULT_LAT
- d_md_use  in  1  instruction reads or writes HI/LO
- flush  in  1  kill all tracked entries (exception/eret)
- stall  out  1  hold PC/F/D and insert a bubble into stage 1
- fwd_rs_sel, fwd_rt_sel  out  SW  0 = register file; k = forward from stage k
- md_busy  out  1  HI/LO unit busy

## Operation
- State: STAGES entries {valid, dst[AW], tnew[TW]} plus a md counter; entry 1 is youngest.
- Each clock, entry k+1 <= entry k, with tnew decremented and saturating at 0; the last entry is dropped.
- Entry 1 loads D when d_valid && !stall && !flush && d_dst != 0 && d_tnew != 0, with tnew = d_tnew-1 (saturating). Otherwise it loads a bubble (valid = 0).
- Operand check (rs and rt independently): skip when tuse = TUSE_NONE or reg = 0. Otherwise find the lowest k with valid && dst == reg. Only the youngest match counts; older matches are ignored.
  - Match with tnew > tuse: hazard.
  - Match with tnew == 0: sel = k.
  - Otherwise: sel = 0, and the downstream stage forwards later.
- stall = d_valid && (rs hazard || rt hazard || ((d_md_use || d_md_start) && md_busy)).
- md counter: on issue (d_valid && !stall && !flush && d_md_start), load DIV_LAT or MULT_LAT. Otherwise decrement while nonzero. md_busy = (counter != 0).
- flush: clears all entry valids at the edge. Entry 1 gets a bubble. The md counter continues. flush overrides stall for capture.
- stall, fwd_*_sel and md_busy are combinational from registered state and D inputs. No combinational path goes from flush to the outputs.

## Timing
- Reset: all valids = 0 and counter = 0. During and after reset, stall = 0, md_busy = 0, sel = 0 for any inputs.
- Reset mid-operation discards all entries and any division in progress on that edge.
- Tnew ageing latency is one cycle per stage. A result that exists in stage j has sel = j in the cycle it reaches tnew = 0.
- Bubbles during stall are inserted in the same cycle stall is high. Stall deasserts in the first cycle the youngest match has tnew ≤ tuse.
- HI/LO: an md instruction in D sees md_busy = 1 for exactly LAT cycles after an issuing mult/div, then proceeds.
- Simultaneous issue of d_md_start while md_busy cannot occur, because it stalls.

## Test plan
- Reset: hold reset 2 cycles with d_valid=1, d_rs=8, d_tuse_rs=0 -> stall=0, md_busy=0, fwd_rs_sel=0.
- Load to branch: issue dst=8 tnew=3, then D rs=8 tuse=0 -> stall=1 for 2 cycles, then stall=0 with fwd_rs_sel=3.
- ALU to ALU: issue dst=9 tnew=2, then D rt=9 tuse=1 -> no stall, fwd_rt_sel=0. With tuse=0 instead -> 1 stall cycle, then fwd_rt_sel=2.
- Youngest wins and $0: two back-to-back writes of reg 10 (tnew=2), then rt=10 tuse=0 -> 1 stall cycle, then fwd_rt_sel=2. Issue dst=0 tnew=3, then rs=0 tuse=0 -> no stall.
- Mult/div: mult (MULT_LAT=5) followed by mfhi -> stall and md_busy high for 5 cycles. div, then reset after 3 cycles -> md_busy=0 the next cycle.
- Flush: load dst=8 tnew=3 in entry 1, assert flush -> the next D rs=8 tuse=0 sees stall=0 and fwd_rs_sel=0.
